// File: rtl/seg7_if.sv
// Signal bundle between the calculator result producer and the 7-segment display driver,
// plus debug visibility of the converter FSM state and the committed digit register.
interface seg7_if;
    logic [12:0] value;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_digits;

    // value is a level, not a handshake: the display tracks it and busy marks a conversion in flight.
    modport master (output value, input seg, an, dp, busy, dbg_state, dbg_digits);
    modport slave  (input value, output seg, an, dp, busy, dbg_state, dbg_digits);
endinterface

// File: rtl/seg7_display.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed 7-segment display.
// Optional macro SEG7_SIGNED_EN: two's-complement input with minus sign and "----" overflow.
module seg7_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    seg7_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t             r_state, w_state_nxt;
    logic [12:0]        r_last_val;
    logic               r_first_pending;
    logic [28:0]        r_shift;
    logic [28:0]        w_adj;
    logic [3:0]         r_bit_cnt;
    logic [15:0]        r_digits;
    logic [CNT_W-1:0]   r_refresh_cnt;
    logic [1:0]         r_idx;
    logic               r_scan_en;
    logic               w_capture;
    logic               w_load;
    logic [12:0]        w_mag;
    logic [3:0]         w_nib [4];
    logic [3:0]         w_blank;
    logic [6:0]         w_seg;

`ifdef SEG7_SIGNED_EN
    logic w_neg, w_ovf;
    logic r_neg_cap, r_ovf_cap, r_neg, r_ovf;
    assign w_neg = bus.value[12];
    assign w_mag = w_neg ? (~bus.value + 13'd1) : bus.value;
    assign w_ovf = w_neg && (w_mag > 13'd999);
`else
    assign w_mag = bus.value;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
            4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
            4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
            4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
            4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
            4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
            4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
            4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((bus.value != r_last_val) || r_first_pending) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == 4'd12) w_state_nxt = DONE;
            end
            DONE: begin
                w_load      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction on the four BCD nibbles sitting above the 13 binary bits.
    always_comb begin
        w_adj = r_shift;
        for (int n = 0; n < 4; n++) begin
            if (r_shift[13 + 4*n +: 4] >= 4'd5)
                w_adj[13 + 4*n +: 4] = r_shift[13 + 4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_last_val      <= '0;
            r_first_pending <= 1'b1;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_digits        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_last_val      <= bus.value;
                r_first_pending <= 1'b0;
                r_shift         <= {16'd0, w_mag};
                r_bit_cnt       <= '0;
            end else if (r_state == SHIFT) begin
                r_shift   <= w_adj << 1;
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_load) r_digits <= r_shift[28:13];
        end
    end

`ifdef SEG7_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_cap <= 1'b0;
            r_ovf_cap <= 1'b0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_neg_cap <= w_neg;
                r_ovf_cap <= w_ovf;
            end
            if (w_load) begin
                r_neg <= r_neg_cap;
                r_ovf <= r_ovf_cap;
            end
        end
    end
`endif

    // The first wrap only enables the anodes, so the scan starts at digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
            r_scan_en     <= 1'b0;
        end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            if (!r_scan_en) r_scan_en <= 1'b1;
            else            r_idx     <= r_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    assign w_nib[0] = r_digits[3:0];
    assign w_nib[1] = r_digits[7:4];
    assign w_nib[2] = r_digits[11:8];
    assign w_nib[3] = r_digits[15:12];

    always_comb begin
        w_blank[0] = 1'b0;
        w_blank[3] = BLANK_LZ && (w_nib[3] == 4'd0);
        w_blank[2] = w_blank[3] && (w_nib[2] == 4'd0);
        w_blank[1] = w_blank[2] && (w_nib[1] == 4'd0);
`ifdef SEG7_SIGNED_EN
        if (r_neg) begin
            w_blank[3] = 1'b0;
            w_blank[2] = BLANK_LZ && (w_nib[2] == 4'd0);
            w_blank[1] = w_blank[2] && (w_nib[1] == 4'd0);
        end
`endif
    end

    always_comb begin
        w_seg = w_blank[r_idx] ? 7'b1111111 : seg_of(w_nib[r_idx]);
`ifdef SEG7_SIGNED_EN
        if (r_ovf || (r_neg && (r_idx == 2'd3))) w_seg = 7'b0111111;
`endif
    end

    assign bus.seg        = r_scan_en ? w_seg : 7'b1111111;
    assign bus.an         = r_scan_en ? ~(4'b0001 << r_idx) : 4'b1111;
    assign bus.dp         = 1'b1;
    assign bus.busy       = (r_state != IDLE);
    assign bus.dbg_state  = r_state;
    assign bus.dbg_digits = r_digits;
endmodule
